// File: rtl/bcd_pkg.sv
// Shared constants and types for the BCD <-> binary converters.
// Holds the bcd2binary FSM state encoding, default sizes, the digit width
// and the digit-correction constants used by binary2bcd.
package bcd_pkg;

    localparam int DEF_DIGITS = 3;
    localparam int DEF_BIN_W  = 10;
    localparam int DIGIT_W    = 4;

    // Reverse double-dabble: a digit >= 8 after a right shift gets 3 taken off.
    localparam logic [DIGIT_W-1:0] B2D_SUB_THRESH = 4'd8;
    localparam logic [DIGIT_W-1:0] B2D_SUB_VAL    = 4'd3;
    localparam logic [DIGIT_W-1:0] BCD_MAX_DIGIT  = 4'd9;

    // Forward double-dabble (binary2bcd): a digit >= 5 gets 3 added before a left shift.
    localparam logic [DIGIT_W-1:0] D2B_ADD_THRESH = 4'd5;
    localparam logic [DIGIT_W-1:0] D2B_ADD_VAL    = 4'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        ADJUST = 2'd2,
        DONE   = 2'd3
    } bcd2bin_state_e;

endpackage

// File: rtl/bcd2bin_adjust.sv
// Single-digit correction for reverse double-dabble: subtract 3 from a
// digit that is 8 or more. Arithmetic wraps in 4 bits; no borrow leaves the digit.
module bcd2bin_adjust
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_i,
    output logic [DIGIT_W-1:0] digit_o
);

    assign digit_o = (digit_i >= B2D_SUB_THRESH) ? (digit_i - B2D_SUB_VAL) : digit_i;

endmodule

// File: rtl/bcd2binary.sv
// Multi-cycle packed-BCD to binary converter (reverse double-dabble).
// A {bcd, bin} shift register is shifted right once and then digit-corrected
// once per iteration; after BIN_W iterations the low BIN_W bits hold the result.
// Optional feature: define BCD2BIN_CHECK_EN to reject operands with a digit > 9
// (short conversion, err set, bin_data left untouched).
module bcd2binary
    import bcd_pkg::*;
#(
    parameter int DIGITS = DEF_DIGITS,
    parameter int BIN_W  = DEF_BIN_W
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst_n,
    input  logic                      start,
    input  logic [DIGIT_W*DIGITS-1:0] bcd_data,
    output logic [BIN_W-1:0]          bin_data,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    localparam int BCD_W = DIGIT_W * DIGITS;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    bcd2bin_state_e     state_q, state_d;
    logic [SR_W-1:0]    sr_q, sr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [BCD_W-1:0]   adj_bcd;

    // One corrector per digit of the BCD half of the shift register.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd2bin_adjust u_adj (
            .digit_i (sr_q[BIN_W + DIGIT_W*g +: DIGIT_W]),
            .digit_o (adj_bcd[DIGIT_W*g +: DIGIT_W])
        );
    end

`ifdef BCD2BIN_CHECK_EN
    logic bad_digit;

    // Flag an operand that contains any non-decimal digit.
    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_data[DIGIT_W*i +: DIGIT_W] > BCD_MAX_DIGIT) begin
                bad_digit = 1'b1;
            end
        end
    end
`endif

    // Next-state and datapath control for the conversion FSM.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        done_d  = 1'b0;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d  = {bcd_data, {BIN_W{1'b0}}};
                    cnt_d = '0;
`ifdef BCD2BIN_CHECK_EN
                    if (bad_digit) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = SHIFT;
                        err_d   = 1'b0;
                    end
`else
                    state_d = SHIFT;
`endif
                end
            end
            SHIFT: begin
                sr_d    = sr_q >> 1;
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = ADJUST;
            end
            ADJUST: begin
                sr_d = {adj_bcd, sr_q[BIN_W-1:0]};
                if (cnt_q < CNT_W'(BIN_W)) begin
                    state_d = SHIFT;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // A rejected operand still pulses done but keeps the old result.
                if (!err_q) begin
                    bin_d = sr_q[BIN_W-1:0];
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset clears everything at once.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            bin_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign busy     = (state_q == SHIFT) || (state_q == ADJUST);
    assign bin_data = bin_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule
